// File: rtl/qiou_word_packer.sv
// Byte-to-word packer: gathers bytes into WORD_BYTES-wide words, tags each word
// with a parity bit and byte count, and hands it off over a valid/ready output.
module qiou_word_packer #(
   parameter int WORD_BYTES = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [7:0]                           in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 mode,
   input  logic                                 flush,
   output logic [8*WORD_BYTES-1:0]              out_data,
   output logic                                 out_parity,
   output logic [$clog2(WORD_BYTES+1)-1:0]      out_bytes,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam int W  = 8 * WORD_BYTES;
   localparam int CW = $clog2(WORD_BYTES);
   localparam int BW = $clog2(WORD_BYTES + 1);

   logic [CW-1:0] r_cnt;
   logic [W-9:0]  r_buf;
   logic [W-1:0]  r_out_data;
   logic          r_out_parity;
   logic [BW-1:0] r_out_bytes;
   logic          r_out_valid;

   logic          w_slot;
   logic          w_last;
   logic          w_ready;
   logic          w_acc;
   logic [W-1:0]  w_byte_sh;
   logic [W-1:0]  w_asm;
   logic [BW-1:0] w_eff;
   logic          w_complete;
   logic          w_flush;
   logic          w_load;

   // Only the final byte of a word needs the output slot; earlier bytes go to the buffer.
   assign w_slot     = !r_out_valid || out_ready;
   assign w_last     = (r_cnt == CW'(WORD_BYTES - 1));
   assign w_ready    = !(w_last && !w_slot);
   assign w_acc      = in_valid && w_ready;
   assign w_byte_sh  = {{(W-8){1'b0}}, in_data} << {r_cnt, 3'b000};
   assign w_asm      = {8'h00, r_buf} | (w_acc ? w_byte_sh : '0);
   assign w_eff      = BW'(r_cnt) + BW'(w_acc);
   assign w_complete = w_acc && w_last;
   assign w_flush    = flush && w_slot && (w_eff != '0);
   assign w_load     = w_complete || w_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_buf        <= '0;
         r_out_data   <= '0;
         r_out_parity <= 1'b0;
         r_out_bytes  <= '0;
         r_out_valid  <= 1'b0;
      end else if (w_load) begin
         r_out_data   <= w_asm;
         r_out_parity <= (^w_asm) ^ mode;
         r_out_bytes  <= w_eff;
         r_out_valid  <= 1'b1;
         r_cnt        <= '0;
         r_buf        <= '0;
      end else begin
         if (out_ready) r_out_valid <= 1'b0;
         if (w_acc) begin
            r_buf <= w_asm[W-9:0];
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign in_ready   = w_ready;
   assign out_data   = r_out_data;
   assign out_parity = r_out_parity;
   assign out_bytes  = r_out_bytes;
   assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_qiou_word_packer.sv
// Bench for qiou_word_packer: byte-queue reference model feeds a scoreboard of
// expected words; a negedge monitor checks handshakes and presented words.
module tb_qiou_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mode = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic        out_parity;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready = 1'b0;

   qiou_word_packer #(.WORD_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .flush(flush),
      .out_data(out_data), .out_parity(out_parity), .out_bytes(out_bytes),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic        p;
      logic [2:0]  n;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] part[$];
   logic       mdl_valid = 1'b0;
   logic       started = 1'b0;
   int         vectors = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic mdl_ready();
      return !(part.size() == 3 && mdl_valid && !out_ready);
   endfunction

   // Reference: a word is the accepted bytes in arrival order, little-endian, zero-padded.
   task automatic mdl_load();
      exp_t e;
      e.w = '0;
      foreach (part[i]) e.w = e.w + (32'(part[i]) << (8 * i));
      e.p = 1'($countones(e.w) % 2) ^ mode;
      e.n = 3'(part.size());
      sb.push_back(e);
      part.delete();
      mdl_valid = 1'b1;
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic f,
                       input logic m, input logic r);
      logic rdy, slot;
      in_valid = v; in_data = d; flush = f; mode = m; out_ready = r;
      @(negedge clk);
      @(posedge clk);
      rdy  = mdl_ready();
      slot = !mdl_valid || out_ready;
      if (in_valid && rdy) part.push_back(in_data);
      if (part.size() == 4) mdl_load();
      else if (flush && slot && part.size() > 0) mdl_load();
      else if (out_ready) mdl_valid = 1'b0;
      #1;
   endtask

   task automatic idle(input logic r);
      step(1'b0, 8'h00, 1'b0, 1'b0, r);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_data"},   out_data,   32'h0);
      chk({tag, "_parity"}, out_parity, 32'h0);
      chk({tag, "_bytes"},  out_bytes,  32'h0);
      chk({tag, "_valid"},  out_valid,  32'h0);
   endtask

   always @(negedge clk) begin
      if (rst_n && started) begin
         chk("in_ready", in_ready, mdl_ready());
         chk("out_valid", out_valid, mdl_valid);
         if (out_valid && sb.size() > 0) begin
            chk("sb_data",   out_data,   sb[0].w);
            chk("sb_parity", out_parity, sb[0].p);
            chk("sb_bytes",  out_bytes,  sb[0].n);
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #1;
      chk_zero_outputs("reset");
      chk("reset_in_ready", in_ready, 32'h1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      started = 1'b1;

      // Basic pack, even then odd parity
      step(1, 8'hFF, 0, 0, 1); step(1, 8'hFF, 0, 0, 1);
      step(1, 8'hFF, 0, 0, 1); step(1, 8'h8F, 0, 0, 1);
      chk("basic_data", out_data, 32'h8FFFFFFF);
      chk("basic_bytes", out_bytes, 32'd4);
      chk("basic_par_even", out_parity, 32'h1);
      step(1, 8'hFF, 0, 1, 1); step(1, 8'hFF, 0, 1, 1);
      step(1, 8'hFF, 0, 1, 1); step(1, 8'h8F, 0, 1, 1);
      chk("basic_par_odd", out_parity, 32'h0);
      idle(1);

      // Backpressure
      step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0);
      step(1, 8'h03, 0, 0, 0); step(1, 8'h04, 0, 0, 0);
      chk("bp_first", out_data, 32'h04030201);
      step(1, 8'h05, 0, 0, 0); step(1, 8'h06, 0, 0, 0); step(1, 8'h07, 0, 0, 0);
      step(1, 8'h08, 0, 0, 0);
      chk("bp_stall", in_ready, 32'h0);
      step(1, 8'h08, 0, 0, 0);
      step(1, 8'h08, 0, 0, 1);
      chk("bp_second", out_data, 32'h08070605);
      chk("bp_valid", out_valid, 32'h1);
      idle(1);

      // Flush cases
      step(1, 8'h12, 0, 0, 1); step(1, 8'h34, 0, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      chk("flush_data", out_data, 32'h00003412);
      chk("flush_bytes", out_bytes, 32'd2);
      chk("flush_par", out_parity, 32'h1);
      idle(1);
      step(0, 8'h00, 1, 0, 1);
      chk("flush_empty", out_valid, 32'h0);
      step(1, 8'h12, 0, 0, 1); step(1, 8'h34, 0, 0, 1);
      step(1, 8'hAB, 1, 0, 1);
      chk("flush_byte_data", out_data, 32'h00AB3412);
      chk("flush_byte_bytes", out_bytes, 32'd3);
      idle(1);

      // Reset mid-word with a word held
      step(1, 8'hC1, 0, 0, 0); step(1, 8'hC2, 0, 0, 0);
      step(1, 8'hC3, 0, 0, 0); step(1, 8'hC4, 0, 0, 0);
      step(1, 8'hAA, 0, 0, 0); step(1, 8'hBB, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("async_rst");
      part.delete(); sb.delete(); mdl_valid = 1'b0;
      in_valid = 1'b0; flush = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      step(1, 8'h11, 0, 0, 1); step(1, 8'h22, 0, 0, 1);
      step(1, 8'h33, 0, 0, 1); step(1, 8'h44, 0, 0, 1);
      chk("post_rst", out_data, 32'h44332211);
      idle(1);

      // Back-to-back streaming
      for (int i = 0; i < 12; i++) step(1, 8'($urandom), 0, 1'($urandom), 1);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
              1'($urandom), $urandom_range(0, 9) < 6);

      for (int i = 0; i < 4; i++) idle(1);
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/qiou_word_packer.md
Name: qiou_word_packer

Overview:
- Upstream feeder for the 32-bit parity stage: packs an 8-bit byte stream into 32-bit words and attaches a parity bit.
- Each word is presented with a valid/ready handshake and a byte count, so the parity stage receives complete words.
- Sits between a byte source (e.g. a serial receiver) and the 32-bit parity/judge stage.

Parameters:
- WORD_BYTES, 4, bytes per output word; out_data width = 8*WORD_BYTES (only 4 is verified).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  packer can accept a byte this cycle.
- mode  input  1  parity mode: 0 = even, 1 = odd; sampled when a word completes.
- flush  input  1  emit the partial word now, zero-padded.
- out_data  output  32  packed word; first accepted byte in [7:0].
- out_parity  output  1  parity bit for out_data under the sampled mode.
- out_bytes  output  3  valid bytes in out_data (1..4).
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_parity=0, out_bytes=0, byte counter cnt=0, assembly buffer=0; in_ready=1 once released.
- Storage: assembly buffer (up to 3 bytes, cnt 0..3) plus one output register.
- Output slot free ("slot") = !out_valid || out_ready.
- Byte accept: in_valid && in_ready. Byte k of a word goes to bits [8k+7:8k], k = cnt.
- in_ready = !(cnt==3 && !slot), combinational. Bytes 0..2 are never stalled; the 4th byte is stalled only while the output is full and not draining.
- Completion (4th byte accepted):
  - word loads into the output register on the same edge; out_valid=1, out_bytes=4, cnt=0, assembly buffer cleared.
  - Latency: word visible the cycle after the 4th byte is accepted.
- Flush:
  - Acts at an edge where flush=1, slot=1, and the effective count is non-zero. Effective count = cnt + (1 if a byte is accepted that edge).
  - Loads the buffer, including any same-cycle byte, zero-padded; out_bytes = effective count; cnt=0.
  - Ignored when the effective count is 0 or slot=0; the source must hold flush.
  - If the same-cycle byte completes the word, normal completion applies and out_bytes=4.
- Parity: p = XOR-reduce of the loaded word. out_parity = p if mode=0 (total ones including parity even), ~p if mode=1. mode is sampled at the load edge; later changes do not alter a held word.
- Drain: out_valid && out_ready with no load on that edge → out_valid=0. out_data, out_parity and out_bytes keep their last values.
- Simultaneous drain and load: new word replaces the old one, out_valid stays 1, no bubble. This sustains 1 byte/cycle.
- Hold: while out_valid && !out_ready, out_data, out_parity and out_bytes are stable.
- Reset mid-word: partial bytes are discarded; the first byte after reset lands in [7:0].

Test Plan:
- Basic pack and parity:
  - Stimulus: mode=0, bytes FF,FF,FF,8F on consecutive cycles, out_ready=1.
  - Required: one cycle after the 8F byte, out_data=32'h8FFFFFFF, out_bytes=4, out_parity=1 (29 ones).
  - Repeat with mode=1: out_parity=0.
- Backpressure:
  - Stimulus: out_ready=0; send 8 bytes 01..08.
  - Required: word 32'h04030201 held; bytes 05,06,07 accepted; in_ready=0 while byte 08 is offered.
  - Raise out_ready for 1 cycle: 32'h08070605 replaces the old word with out_valid held at 1.
- Flush partial:
  - Stimulus: bytes 12,34, then flush=1 with in_valid=0, mode=0.
  - Required: out_data=32'h00003412, out_bytes=2, out_parity=1; cnt returns to 0.
- Flush edge cases:
  - Flush with cnt=0 and no byte: no output.
  - Flush together with a 3rd byte AB after 12,34: out_data=32'h00AB3412, out_bytes=3.
- Reset mid-word:
  - Stimulus: bytes AA,BB, then assert rst_n=0 asynchronously, release, then bytes 11,22,33,44.
  - Required: all outputs 0 immediately on reset; next word 32'h44332211.
- Back-to-back streaming:
  - Stimulus: out_ready=1, 12 bytes in 12 cycles.
  - Required: in_ready never drops; 3 words emitted, with out_valid high on the cycles after each 4th byte.
